// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer and its slow-rate helpers.
package btn_debounce_pkg;

   // Debounce FSM states; encodings are fixed so other blocks can decode them.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM_P = 2'd1,
      DOWN  = 2'd2,
      ARM_R = 2'd3
   } state_t;

   // Bits needed for a counter that must be able to hold max_val itself.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clk cycles.
module tick_gen
   import btn_debounce_pkg::*;
#(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            CW   = cnt_width(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // Count 0..TICK_DIV-1 and wrap; only reset ever restarts the phase.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchroniser, tick-sampled stability FSM, long-press detect.
module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 10,
   parameter int HOLD_TICKS   = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int            SW        = cnt_width(STABLE_TICKS);
   localparam int            HW        = cnt_width(HOLD_TICKS);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

   logic          s1;
   logic          s;
   logic          tick;
   logic          press_go;
   state_t        state;
   logic [SW-1:0] stab;
   logic [HW-1:0] hold;

   tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   // Two-flop synchroniser for the asynchronous button; only s is used below.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s  <= 1'b0;
      end else begin
         s1 <= btn_in;
         s  <= s1;
      end
   end

   // The press is accepted on this exact condition; the hold counter restarts with it.
   assign press_go = (state == ARM_P) && s && tick && (stab == STAB_LAST);

   // Stability FSM with registered level and one-cycle press/release pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         stab          <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         // NOTE: pulses default low every cycle so each one lasts exactly one clock.
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (s) begin
                  state <= ARM_P;
                  stab  <= '0;
               end
            end
            ARM_P: begin
               if (!s) begin
                  state <= IDLE;
               end else if (tick) begin
                  stab <= stab + SW'(1);
                  if (stab == STAB_LAST) begin
                     state       <= DOWN;
                     btn_level   <= 1'b1;
                     press_pulse <= 1'b1;
                  end
               end
            end
            DOWN: begin
               if (!s) begin
                  state <= ARM_R;
                  stab  <= '0;
               end
            end
            ARM_R: begin
               if (s) begin
                  state <= DOWN;
               end else if (tick) begin
                  stab <= stab + SW'(1);
                  if (stab == STAB_LAST) begin
                     state         <= IDLE;
                     btn_level     <= 1'b0;
                     release_pulse <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Ticks held down since acceptance; saturates so long_pulse fires once per press.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold       <= '0;
         long_pulse <= 1'b0;
      end else begin
         long_pulse <= 1'b0;
         if (press_go) begin
            hold <= '0;
         end else if (tick && ((state == DOWN) || (state == ARM_R)) && (hold != HOLD_MAX)) begin
            hold <= hold + HW'(1);
            if (hold == HOLD_LAST) begin
               long_pulse <= 1'b1;
            end
         end
      end
   end

endmodule
